// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential fixed-point multiplier.
// Default widths give a Q16.16 x Q16.16 -> Q4.28 product.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_I_WIDTH     = 16;
  localparam int DEF_F_WIDTH     = 16;
  localparam int DEF_OUT_I_WIDTH = 4;
  localparam int DEF_OUT_F_WIDTH = 28;
  localparam int DEF_W           = DEF_I_WIDTH + DEF_F_WIDTH;

  // Saturation limits of a DEF_W-bit signed result.
  localparam logic [DEF_W-1:0] DEF_SAT_POS = {1'b0, {(DEF_W-1){1'b1}}};
  localparam logic [DEF_W-1:0] DEF_SAT_NEG = {1'b1, {(DEF_W-1){1'b0}}};

endpackage

// File: rtl/seq_multiplier_scale_sat.sv
// Combinational rescale of the magnitude product: truncating right shift,
// saturation to the signed W-bit range, then sign application.
module mul_scale_sat #(
  parameter int W     = 32,
  parameter int SHIFT = 4
) (
  input  logic [2*W-1:0] i_prod,
  input  logic           i_sign,
  output logic [W-1:0]   o_out,
  output logic           o_ovf
);

  localparam logic [2*W-1:0] LIM_POS = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] LIM_NEG = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

  logic [2*W-1:0] w_mag;

  assign w_mag = i_prod >> SHIFT;

  // Negating a zero magnitude yields zero, so a negative-signed zero is clean.
  always_comb begin
    o_out = '0;
    o_ovf = 1'b0;
    if (!i_sign) begin
      if (w_mag > LIM_POS) begin
        o_out = {1'b0, {(W-1){1'b1}}};
        o_ovf = 1'b1;
      end else begin
        o_out = w_mag[W-1:0];
      end
    end else begin
      if (w_mag > LIM_NEG) begin
        o_out = {1'b1, {(W-1){1'b0}}};
        o_ovf = 1'b1;
      end else begin
        o_out = -w_mag[W-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add signed fixed-point multiplier: one multiplier bit per
// cycle on operand magnitudes, then a single rescale/saturate cycle.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int I_WIDTH     = DEF_I_WIDTH,
  parameter int F_WIDTH     = DEF_F_WIDTH,
  parameter int OUT_I_WIDTH = DEF_OUT_I_WIDTH,
  parameter int OUT_F_WIDTH = DEF_OUT_F_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [I_WIDTH+F_WIDTH-1:0] A_in,
  input  logic signed [I_WIDTH+F_WIDTH-1:0] B_in,
  input  logic                              in_valid,
  output logic                              ready,
  output logic                              out_valid,
  output logic signed [I_WIDTH+F_WIDTH-1:0] out,
  output logic                              overflow,
  output state_t                            o_dbg_state
);

  // Handshake: an operation is accepted on a rising edge where ready (IDLE)
  // and in_valid are both high; out_valid is a single-cycle pulse with no
  // back-pressure, and in_valid while busy is dropped rather than queued.

  localparam int W     = I_WIDTH + F_WIDTH;
  localparam int SHIFT = 2*F_WIDTH - OUT_F_WIDTH;
  localparam int CW    = $clog2(W) + 1;

  state_t         r_state, w_next;
  logic [2*W-1:0] r_a, r_acc;
  logic [W-1:0]   r_b, r_out, w_a_mag, w_b_mag, w_out;
  logic [CW-1:0]  r_cnt;
  logic           r_sign, r_ovf, r_out_valid, w_ovf, w_last;

  // Most-negative input maps to 2^(W-1), which still fits unsigned W bits.
  assign w_a_mag = A_in[W-1] ? -A_in : A_in;
  assign w_b_mag = B_in[W-1] ? -B_in : B_in;
  assign w_last  = (r_cnt == CW'(W-1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = MULT;
      MULT:    if (w_last) w_next = SCALE;
      SCALE:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_out       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (r_state == DONE);
      case (r_state)
        IDLE: if (in_valid) begin
          r_a    <= {{W{1'b0}}, w_a_mag};
          r_b    <= w_b_mag;
          r_sign <= A_in[W-1] ^ B_in[W-1];
          r_acc  <= '0;
          r_cnt  <= '0;
        end
        MULT: begin
          if (r_b[0]) r_acc <= r_acc + r_a;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
        end
        SCALE: begin
          r_out <= w_out;
          r_ovf <= w_ovf;
        end
        default: ;
      endcase
    end
  end

  mul_scale_sat #(
    .W     (W),
    .SHIFT (SHIFT)
  ) u_scale_sat (
    .i_prod (r_acc),
    .i_sign (r_sign),
    .o_out  (w_out),
    .o_ovf  (w_ovf)
  );

  assign ready       = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign out         = r_out;
  assign overflow    = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at default widths (Q16.16 -> Q4.28):
// directed limit cases, busy/back-to-back/abort scenarios, then random traffic.
module tb_seq_multiplier;
  import seq_multiplier_pkg::*;

  localparam int W     = 32;
  localparam int LAT   = W + 2;
  localparam int SHIFT = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [W-1:0] A_in = '0;
  logic signed [W-1:0] B_in = '0;
  logic                in_valid = 1'b0;
  logic                ready, out_valid, overflow;
  logic signed [W-1:0] out;
  state_t              dbg_state;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  logic [W:0] exp_q[$];
  int         acc_q[$];

  seq_multiplier dut (
    .clk         (clk),
    .rst         (rst),
    .A_in        (A_in),
    .B_in        (B_in),
    .in_valid    (in_valid),
    .ready       (ready),
    .out_valid   (out_valid),
    .out         (out),
    .overflow    (overflow),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact product, truncated toward zero at the output scale, then clamped.
  function automatic logic [W:0] model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    longint p, q;
    p = longint'(a) * longint'(b);
    q = (p < 0) ? -((-p) >>> SHIFT) : (p >>> SHIFT);
    if (q > longint'(DEF_SAT_POS)) return {1'b1, DEF_SAT_POS};
    if (q < -longint'({1'b0, DEF_SAT_NEG})) return {1'b1, DEF_SAT_NEG};
    return {1'b0, q[W-1:0]};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic signed [W-1:0] a, input logic signed [W-1:0] b, input bit hold);
    int waited = 0;
    while (!ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    A_in = a;
    B_in = b;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b));
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic monitor();
    logic [W:0] e;
    int t;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          chk("result", longint'({overflow, out}), longint'(e));
          chk("latency", cyc - t, LAT);
        end
      end
    end
  endtask

  task automatic stimulus();
    logic signed [W-1:0] ra, rb;
    int waited;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_out", out, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_out_valid", out_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h0001_8000, 32'h0002_0000, 1'b0);
    issue(32'hFFFE_8000, 32'h0002_0000, 1'b0);
    issue(32'h0000_0000, 32'h8000_0000, 1'b0);
    issue(32'h0004_0000, 32'h0002_0000, 1'b0);
    issue(32'hFFFC_0000, 32'h0002_0000, 1'b0);
    issue(32'hFFFC_0000, 32'h0004_0000, 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0);

    // Operands offered while busy must be dropped.
    issue(32'h0001_8000, 32'h0002_0000, 1'b0);
    repeat (5) @(negedge clk);
    chk("busy_ready", ready, 0);
    A_in = 32'h7FFF_0000;
    B_in = 32'h7123_4567;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;

    // in_valid held high: second accept exactly W+3 edges after the first.
    issue(32'h0003_0000, 32'hFFFF_4000, 1'b1);
    A_in = 32'h0000_C000;
    B_in = 32'h0005_0000;
    exp_q.push_back(model(32'h0000_C000, 32'h0005_0000));
    acc_q.push_back(cyc + W + 3);
    repeat (W + 3) @(negedge clk);
    in_valid = 1'b0;

    // Abort mid-MULT with reset; the aborted op must never report.
    issue(32'h0002_0000, 32'h0003_0000, 1'b0);
    repeat (9) @(negedge clk);
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_out", out, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_out_valid", out_valid, 0);
    repeat (W + 6) @(negedge clk);
    issue(32'h0001_8000, 32'h0002_0000, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) != 0) ra = ra >>> $urandom_range(8, 24);
      if ($urandom_range(0, 3) != 0) rb = rb >>> $urandom_range(8, 24);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(ra, rb, 1'b0);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter I_WIDTH, default 16: integer bits of the operands.
REQ-002 SHALL have parameter F_WIDTH, default 16: fraction bits of the operands.
REQ-003 SHALL have parameter OUT_I_WIDTH, default 4: integer bits of the result.
REQ-004 SHALL have parameter OUT_F_WIDTH, default 28: fraction bits of the result; legal only when I_WIDTH+F_WIDTH = OUT_I_WIDTH+OUT_F_WIDTH and OUT_F_WIDTH <= 2*F_WIDTH.
REQ-005 SHALL have clk, input, 1: clock; all state changes on the rising edge.
REQ-006 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have A_in, input, W=I_WIDTH+F_WIDTH, signed: multiplicand in Q(I.F) format.
REQ-008 SHALL have B_in, input, W, signed: multiplier in Q(I.F) format.
REQ-009 SHALL have in_valid, input, 1: operands are valid.
REQ-010 SHALL have ready, output, 1: block is idle and accepts operands.
REQ-011 SHALL have out_valid, output, 1: out and overflow are valid (one-cycle pulse).
REQ-012 SHALL have out, output, W, signed: product in Q(OUT_I.OUT_F) format.
REQ-013 SHALL have overflow, output, 1: out was saturated.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, MULT, SCALE, DONE.
REQ-015 In IDLE, ready SHALL be 1; in all other states ready SHALL be 0.
REQ-016 SHALL accept operands only in IDLE with in_valid=1, at that edge:
- capture |A_in| and |B_in| as W-bit unsigned magnitudes (most-negative input gives 2^(W-1));
- capture sign = A_in[W-1] xor B_in[W-1];
- clear the 2W-bit accumulator and the bit counter;
- go to MULT.
REQ-017 in_valid outside IDLE SHALL be ignored (no queuing).
REQ-018 MULT SHALL do radix-2 shift-add: one multiplier bit per cycle, LSB first, for exactly W cycles, then go to SCALE.
REQ-019 SCALE SHALL take one cycle:
- shift the 2W-bit magnitude product right by 2*F_WIDTH-OUT_F_WIDTH (truncation toward zero);
- saturate;
- apply the sign;
- register out and overflow;
- go to DONE.
REQ-020 Saturation SHALL be:
- positive result with magnitude > 2^(W-1)-1: out = 2^(W-1)-1, overflow = 1;
- negative result with magnitude > 2^(W-1): out = -2^(W-1), overflow = 1;
- otherwise overflow = 0.
REQ-021 A zero product SHALL give out = 0 regardless of sign (no negative zero issue).
REQ-022 DONE SHALL assert out_valid for exactly one cycle, then go to IDLE.
REQ-023 Latency SHALL be fixed: out_valid is high in the cycle after edge W+2, counting the accepting edge as edge 0 (34 cycles at defaults).
REQ-024 Throughput SHALL be one operation per W+3 cycles; a new accept is possible in the cycle after DONE.
REQ-025 out and overflow SHALL hold their values until the next SCALE.

Reset
REQ-026 rst=1 at a clock edge SHALL force:
- state = IDLE;
- out = 0, overflow = 0, out_valid = 0;
- counter = 0, accumulator = 0.
REQ-027 rst SHALL abort an operation in progress with no out_valid for it; ready = 1 in the cycle after reset is released.
REQ-028 rst SHALL take priority over in_valid in the same cycle.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state type;
- default width constants;
- the saturation limit constants.
REQ-030 One combinational sub-module, mul_scale_sat, SHALL perform the shift, saturation and sign application used in SCALE.

Verification (defaults, Q16.16 in, Q4.28 out)
REQ-031 A=0x00018000 (1.5), B=0x00020000 (2.0) -> out=0x30000000, overflow=0, out_valid exactly 34 cycles after accept.
REQ-032 A=0xFFFE8000 (-1.5), B=0x00020000 -> out=0xD0000000, overflow=0; A=0, B=0x80000000 -> out=0x00000000, overflow=0.
REQ-033 Saturation and limit cases:
- A=0x00040000 (4.0), B=0x00020000 -> out=0x7FFFFFFF, overflow=1;
- A=0xFFFC0000 (-4.0), B=0x00020000 -> out=0x80000000, overflow=0;
- A=0xFFFC0000, B=0x00040000 -> out=0x80000000, overflow=1.
REQ-034 Pulse in_valid with new operands while in MULT -> they are ignored and the first result is unchanged; back-to-back in_valid held high -> a second accept in the cycle after DONE.
REQ-035 Assert rst for 1 cycle at MULT cycle 10 -> no out_valid, out=0, ready=1 next cycle; a following 1.5*2.0 gives 0x30000000.
